mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Holds the EX/MEM pipeline register and drives a single-port data-memory bus with a req/ack handshake, variable wait states and a timeout. Performs byte/half/word lane alignment with sign/zero extension, and stalls upstream stages while an access is outstanding. Produces the MEM/WB register contents and the MEM-stage forwarding value and controls used by the execute-stage forwarder.

## Interface
- ACK_TIMEOUT, 255: max cycles DM_Req stays high without DM_Ack before abort (1..65535)
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- EX_Valid  in  1  EX result valid (0 = bubble)
- EX_ALUResult  in  32  address for loads/stores, result otherwise
- EX_WriteData  in  32  store data (already forwarded)
- EX_RegDest  in  5  destination register
- EX_RegWrite  in  1  instruction writes RF
- EX_MemRead / EX_MemWrite  in  1 each  load / store (never both)
- EX_MemSize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- EX_MemSigned  in  1  sign-extend loads
- DM_Req  out  1  access request
- DM_Write  out  1  1 store, 0 load
- DM_Addr  out  32  word-aligned address ({addr[31:2],2'b00})
- DM_WData  out  32  lane-replicated store data
- DM_ByteEn  out  4  lane enables, bit 0 = byte addr 0 (little-endian)
- DM_Ack  in  1  access complete; DM_RData valid same cycle
- DM_RData  in  32  read word
- Stall  out  1  hold EX and earlier stages
- FWFromMEM  out  32  latched ALUResult
- EXMEM_RegDest  out  5  latched RegDest
- EXMEM_WriteEnable  out  1  latched RegWrite & Valid
- WB_Valid, WB_RegWrite  out  1 each  MEM/WB controls
- WB_RegDest  out  5
- WB_Data  out  32  load data or ALU result
- MisalignedExc  out  1  one-cycle pulse
- BusError  out  1  one-cycle pulse on timeout

## Operation
- EX/MEM register loads all EX_* inputs on an edge with Stall=0; holds when Stall=1.
- States: IDLE, WAIT.
- IDLE: latched memory op, aligned -> DM_Req=1. With DM_Ack=1: access completes this cycle. Otherwise next state WAIT and counter clears to 0.
- WAIT: DM_Req, DM_Write, DM_Addr, DM_WData and DM_ByteEn are held stable. DM_Ack -> IDLE. Counter reaching ACK_TIMEOUT-1 without ack -> abort: DM_Req drops, BusError pulses, WB write suppressed, back to IDLE.
- Stall = memory op latched & aligned & !DM_Ack & !timeout-abort (combinational).
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. No request is issued; MisalignedExc pulses; WB_RegWrite=0; no stall.
- Store lanes:
  - byte: data[7:0] replicated x4, ByteEn=0001<<addr[1:0]
  - half: data[15:0] x2, ByteEn=0011<<addr[1:0]
  - word: ByteEn=1111
- Load: select lane by addr[1:0], then sign- or zero-extend per EX_MemSigned.
- WB_Data = aligned load data for loads, latched ALUResult otherwise.
- MEM/WB register updates every edge. While Stall=1 it loads a bubble (WB_Valid=0, WB_RegWrite=0).
- Loads forward the address, not the data, on FWFromMEM. Load-use hazards belong to the hazard unit, not this block.
- DM_Ack while DM_Req=0 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, both pipeline registers cleared (Valid=0).
- Non-memory op: 1 cycle EX/MEM -> MEM/WB.
- Zero-wait access: 1 cycle, no stall.
- N wait states: Stall high for N cycles; WB gets the load data on the edge where DM_Ack=1.
- Reset during WAIT: next cycle DM_Req=0, state IDLE, no WB write and no BusError.
- A bubble (EX_Valid=0) never requests memory, even if MemRead/MemWrite are set.

## Structure
- mem_stage_pkg holds:
  - MemSize encodings (MEM_WORD, MEM_HALF, MEM_BYTE)
  - state enum
  - timeout counter width derivation
- Sub-module load_store_aligner (combinational): store lane replication, ByteEn generation, load lane select and extension, misalignment detect.

## Test plan
- ALU op, EX_ALUResult=0x1234, RegDest=5, RegWrite=1 -> next cycle FWFromMEM=0x1234 and EXMEM_WriteEnable=1; following cycle WB_Data=0x1234, WB_RegDest=5.
- lb, addr=0x103, signed, DM_RData=0x80FFFFFF, zero-wait -> WB_Data=0xFFFFFF80, no Stall. Same access with lbu -> 0x00000080.
- sh, addr=0x102, data=0xAAAABEEF -> DM_WData=0xBEEFBEEF, ByteEn=1100, DM_Write=1.
- lw with Ack delayed 3 cycles:
  - Stall high 3 cycles, DM_Addr held stable, 3 bubbles in WB.
  - Data lands on the ack edge.
  - Upstream EX inputs are held and not lost.
- lw at addr=0x102 -> MisalignedExc pulse, DM_Req stays 0, WB_RegWrite=0.
- ACK_TIMEOUT=4, no Ack -> BusError pulse after 4 request cycles, Stall released, no WB write.
- Reset asserted in WAIT -> DM_Req 0 next cycle; a late Ack is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_HALF = 2'b01,
    MEM_BYTE = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   size;
    logic        sgn;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } mem_wb_t;

  // Counter holds 0..timeout-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory bus with req/ack handshake.
interface mem_stage_if;
  logic        DM_Req;
  logic        DM_Write;
  logic [31:0] DM_Addr;
  logic [31:0] DM_WData;
  logic [3:0]  DM_ByteEn;
  logic        DM_Ack;
  logic [31:0] DM_RData;

  modport master (
    output DM_Req, DM_Write, DM_Addr, DM_WData, DM_ByteEn,
    input  DM_Ack, DM_RData
  );

  modport slave (
    input  DM_Req, DM_Write, DM_Addr, DM_WData, DM_ByteEn,
    output DM_Ack, DM_RData
  );
endinterface

// File: rtl/load_store_aligner.sv
// Combinational lane steering: store replication, byte enables, load extract/extend, alignment.
module load_store_aligner
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  mem_size_e   size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rshift = rdata_i >> {addr_i, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wdata_o      = wdata_i;
    byte_en_o    = 4'b1111;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_BYTE: begin
        wdata_o   = {4{wdata_i[7:0]}};
        byte_en_o = 4'b0001 << addr_i;
        rdata_o   = {{24{signed_i & rbyte[7]}}, rbyte};
      end
      MEM_HALF: begin
        misaligned_o = addr_i[0];
        wdata_o      = {2{wdata_i[15:0]}};
        byte_en_o    = 4'b0011 << addr_i;
        rdata_o      = {{16{signed_i & rhalf[15]}}, rhalf};
      end
      // Word and the reserved encoding behave identically.
      default: begin
        misaligned_o = |addr_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory handshake with timeout, MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        EX_Valid,
  input  logic [31:0] EX_ALUResult,
  input  logic [31:0] EX_WriteData,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic [1:0]  EX_MemSize,
  input  logic        EX_MemSigned,
  mem_stage_if.master dm,
  output logic        Stall,
  output logic [31:0] FWFromMEM,
  output logic [4:0]  EXMEM_RegDest,
  output logic        EXMEM_WriteEnable,
  output logic        WB_Valid,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_RegDest,
  output logic [31:0] WB_Data,
  output logic        MisalignedExc,
  output logic        BusError
);

  localparam int unsigned CntW = cnt_width(ACK_TIMEOUT);

  ex_mem_t         exmem_q, exmem_d;
  mem_wb_t         wb_q, wb_d;
  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_byte_en;
  logic        misaligned;
  logic        mem_op, access, abort, dm_req, ack;

  load_store_aligner u_aligner (
    .addr_i       (exmem_q.alu[1:0]),
    .size_i       (exmem_q.size),
    .signed_i     (exmem_q.sgn),
    .wdata_i      (exmem_q.wdata),
    .rdata_i      (dm.DM_RData),
    .wdata_o      (st_wdata),
    .byte_en_o    (st_byte_en),
    .rdata_o      (ld_data),
    .misaligned_o (misaligned)
  );

  assign mem_op = exmem_q.valid & (exmem_q.mem_read | exmem_q.mem_write);
  assign access = mem_op & ~misaligned;
  assign abort  = (state_q == StWait) & (cnt_q == CntW'(ACK_TIMEOUT - 1));
  assign dm_req = access & ~abort;
  // An ack only counts while a request is actually on the bus.
  assign ack    = dm.DM_Ack & dm_req;
  assign Stall  = dm_req & ~dm.DM_Ack;

  assign dm.DM_Req    = dm_req;
  assign dm.DM_Write  = dm_req & exmem_q.mem_write;
  assign dm.DM_Addr   = dm_req ? {exmem_q.alu[31:2], 2'b00} : 32'd0;
  assign dm.DM_WData  = dm_req ? st_wdata : 32'd0;
  assign dm.DM_ByteEn = dm_req ? st_byte_en : 4'd0;

  assign MisalignedExc = mem_op & misaligned & ~Reset;
  assign BusError      = abort & ~Reset;

  assign FWFromMEM         = exmem_q.alu;
  assign EXMEM_RegDest     = exmem_q.rd;
  assign EXMEM_WriteEnable = exmem_q.valid & exmem_q.reg_write;

  assign WB_Valid    = wb_q.valid;
  assign WB_RegWrite = wb_q.reg_write;
  assign WB_RegDest  = wb_q.rd;
  assign WB_Data     = wb_q.data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (dm_req && !dm.DM_Ack) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (ack || abort || !access) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    exmem_d = exmem_q;
    if (!Stall) begin
      exmem_d.valid     = EX_Valid;
      exmem_d.alu       = EX_ALUResult;
      exmem_d.wdata     = EX_WriteData;
      exmem_d.rd        = EX_RegDest;
      exmem_d.reg_write = EX_RegWrite;
      exmem_d.mem_read  = EX_MemRead;
      exmem_d.mem_write = EX_MemWrite;
      exmem_d.size      = mem_size_e'(EX_MemSize);
      exmem_d.sgn       = EX_MemSigned;
    end
  end

  // Aborted or misaligned loads never write back; their data falls back to the address.
  always_comb begin
    wb_d = '0;
    if (!Stall) begin
      wb_d.valid     = exmem_q.valid;
      wb_d.reg_write = exmem_q.valid & exmem_q.reg_write & ~(mem_op & misaligned) & ~abort;
      wb_d.rd        = exmem_q.rd;
      wb_d.data      = (exmem_q.mem_read && ack) ? ld_data : exmem_q.alu;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      exmem_q <= '0;
      wb_q    <= '0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      exmem_q <= exmem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: ALU pass-through, aligned loads/stores, wait states, faults.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_rw;
  logic        ex_mr;
  logic        ex_mw;
  logic [1:0]  ex_size;
  logic        ex_sgn;
  logic        stall;
  logic [31:0] fw_mem;
  logic [4:0]  exmem_rd;
  logic        exmem_we;
  logic        wb_valid;
  logic        wb_rw;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mis_exc;
  logic        bus_err;

  mem_stage_if dm_bus ();

  mem_stage #(
    .ACK_TIMEOUT (4)
  ) dut (
    .Clock             (clk),
    .Reset             (rst),
    .EX_Valid          (ex_valid),
    .EX_ALUResult      (ex_alu),
    .EX_WriteData      (ex_wdata),
    .EX_RegDest        (ex_rd),
    .EX_RegWrite       (ex_rw),
    .EX_MemRead        (ex_mr),
    .EX_MemWrite       (ex_mw),
    .EX_MemSize        (ex_size),
    .EX_MemSigned      (ex_sgn),
    .dm                (dm_bus),
    .Stall             (stall),
    .FWFromMEM         (fw_mem),
    .EXMEM_RegDest     (exmem_rd),
    .EXMEM_WriteEnable (exmem_we),
    .WB_Valid          (wb_valid),
    .WB_RegWrite       (wb_rw),
    .WB_RegDest        (wb_rd),
    .WB_Data           (wb_data),
    .MisalignedExc     (mis_exc),
    .BusError          (bus_err)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                          input logic [1:0] sz, input logic sg);
    ex_valid = v;
    ex_alu   = alu;
    ex_wdata = wd;
    ex_rd    = rd;
    ex_rw    = rw;
    ex_mr    = mr;
    ex_mw    = mw;
    ex_size  = sz;
    ex_sgn   = sg;
  endtask

  task automatic drive_bubble();
    drive_ex(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input logic we);
    wb_exp_t e;
    e.rd   = rd;
    e.data = data;
    e.we   = we;
    sb_q.push_back(e);
  endtask

  // WB is sampled 2 ns after each rising edge, clear of the negedge-driven stimulus.
  always @(posedge clk) begin
    wb_exp_t e;
    #2;
    if (wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("wb_rd", 32'(wb_rd), 32'(e.rd));
        check_eq("wb_data", wb_data, e.data);
        check_eq("wb_we", 32'(wb_rw), 32'(e.we));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_bubble();
    dm_bus.DM_Ack   = 1'b0;
    dm_bus.DM_RData = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req", 32'(dm_bus.DM_Req), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
    check_eq("rst_fw", fw_mem, 32'd0);
    check_eq("rst_exmem_we", 32'(exmem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ALU op passes through in one cycle per register.
    drive_ex(1'b1, 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    push_exp(5'd5, 32'h1234, 1'b1);
    @(negedge clk);
    drive_bubble();
    #1;
    check_eq("alu_fw", fw_mem, 32'h1234);
    check_eq("alu_exmem_we", 32'(exmem_we), 32'd1);
    check_eq("alu_exmem_rd", 32'(exmem_rd), 32'd5);
    check_eq("alu_req", 32'(dm_bus.DM_Req), 32'd0);
    @(negedge clk);

    // lb / lbu at byte 3, zero-wait.
    for (int s = 1; s >= 0; s--) begin
      drive_ex(1'b1, 32'h103, 32'd0, 5'(7 - s), 1'b1, 1'b1, 1'b0, 2'b10, 1'(s));
      push_exp(5'(7 - s), (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080, 1'b1);
      @(negedge clk);
      drive_bubble();
      dm_bus.DM_Ack   = 1'b1;
      dm_bus.DM_RData = 32'h80FF_FFFF;
      #1;
      check_eq("lb_req", 32'(dm_bus.DM_Req), 32'd1);
      check_eq("lb_write", 32'(dm_bus.DM_Write), 32'd0);
      check_eq("lb_addr", dm_bus.DM_Addr, 32'h100);
      check_eq("lb_stall", 32'(stall), 32'd0);
      @(negedge clk);
      dm_bus.DM_Ack = 1'b0;
    end

    // sh at 0x102 and sb at 0x101.
    drive_ex(1'b1, 32'h102, 32'hAAAA_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    push_exp(5'd0, 32'h102, 1'b0);
    @(negedge clk);
    drive_ex(1'b1, 32'h101, 32'h1234_565A, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    push_exp(5'd0, 32'h101, 1'b0);
    dm_bus.DM_Ack = 1'b1;
    #1;
    check_eq("sh_wdata", dm_bus.DM_WData, 32'hBEEF_BEEF);
    check_eq("sh_byte_en", 32'(dm_bus.DM_ByteEn), 32'hC);
    check_eq("sh_write", 32'(dm_bus.DM_Write), 32'd1);
    check_eq("sh_addr", dm_bus.DM_Addr, 32'h100);
    @(negedge clk);
    drive_bubble();
    #1;
    check_eq("sb_wdata", dm_bus.DM_WData, 32'h5A5A_5A5A);
    check_eq("sb_byte_en", 32'(dm_bus.DM_ByteEn), 32'h2);
    @(negedge clk);
    dm_bus.DM_Ack = 1'b0;
    @(negedge clk);

    // lw with three wait states; the following ALU op must be held, not lost.
    drive_ex(1'b1, 32'h200, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    push_exp(5'd8, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    drive_ex(1'b1, 32'h55, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    push_exp(5'd9, 32'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("lw_wait_stall", 32'(stall), 32'd1);
      check_eq("lw_wait_req", 32'(dm_bus.DM_Req), 32'd1);
      check_eq("lw_wait_addr", dm_bus.DM_Addr, 32'h200);
      check_eq("lw_wait_fw", fw_mem, 32'h200);
      if (i > 0) check_eq("lw_wait_bubble", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    dm_bus.DM_Ack   = 1'b1;
    dm_bus.DM_RData = 32'hCAFE_F00D;
    #1;
    check_eq("lw_ack_stall", 32'(stall), 32'd0);
    check_eq("lw_ack_bubble", 32'(wb_valid), 32'd0);
    @(negedge clk);
    dm_bus.DM_Ack = 1'b0;
    drive_bubble();
    #1;
    check_eq("lw_next_fw", fw_mem, 32'h55);
    @(negedge clk);

    // Misaligned word load.
    drive_ex(1'b1, 32'h102, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    push_exp(5'd10, 32'h102, 1'b0);
    @(negedge clk);
    drive_bubble();
    #1;
    check_eq("mis_exc", 32'(mis_exc), 32'd1);
    check_eq("mis_req", 32'(dm_bus.DM_Req), 32'd0);
    check_eq("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq("mis_pulse_end", 32'(mis_exc), 32'd0);

    // Bubble carrying MemRead must not request.
    drive_ex(1'b0, 32'h500, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    drive_bubble();
    #1;
    check_eq("bubble_req", 32'(dm_bus.DM_Req), 32'd0);
    @(negedge clk);

    // Timeout with ACK_TIMEOUT=4: four request cycles, then abort.
    drive_ex(1'b1, 32'h300, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    push_exp(5'd11, 32'h300, 1'b0);
    @(negedge clk);
    drive_bubble();
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("to_req", 32'(dm_bus.DM_Req), 32'd1);
      check_eq("to_stall", 32'(stall), 32'd1);
      check_eq("to_no_err", 32'(bus_err), 32'd0);
      @(negedge clk);
    end
    #1;
    check_eq("to_abort_req", 32'(dm_bus.DM_Req), 32'd0);
    check_eq("to_bus_err", 32'(bus_err), 32'd1);
    check_eq("to_abort_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq("to_err_pulse_end", 32'(bus_err), 32'd0);
    @(negedge clk);

    // Reset while waiting; a late ack must be ignored.
    drive_ex(1'b1, 32'h400, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    drive_bubble();
    @(negedge clk);
    #1;
    check_eq("rw_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dm_bus.DM_Ack   = 1'b1;
    dm_bus.DM_RData = 32'hDEAD_BEEF;
    #1;
    check_eq("rw_req", 32'(dm_bus.DM_Req), 32'd0);
    check_eq("rw_stall_clr", 32'(stall), 32'd0);
    check_eq("rw_bus_err", 32'(bus_err), 32'd0);
    check_eq("rw_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    dm_bus.DM_Ack = 1'b0;
    #1;
    check_eq("rw_late_ack_wb", 32'(wb_valid), 32'd0);
    repeat (2) @(negedge clk);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
